au_fir_eq: RTL and testbench



---
 rtl/au_filt_pkg.sv | 19 +
 rtl/au_eq_stage.sv | 56 +++++
 rtl/au_fir_eq.sv | 76 +++++++
 tb/tb_au_fir_eq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/au_filt_pkg.sv
// au_filt_pkg: shared constants, coefficients and preset types for the au_fir_eq filter chain.
package au_filt_pkg;
  localparam int NTAPS = 16;
  localparam int ACC_W = 44;
  localparam int EQ_W = 29;
  localparam int G_UNITY = 8;
  localparam int G_BOOST = 16;
  localparam logic signed [15:0] FIR_COEF [0:NTAPS-1] = '{
    16'sd100, 16'sd300, 16'sd700, 16'sd1200, 16'sd1900, 16'sd2700, 16'sd3900, 16'sd5584,
    16'sd5584, 16'sd3900, 16'sd2700, 16'sd1900, 16'sd1200, 16'sd700, 16'sd300, 16'sd100
  };
  typedef enum logic [1:0] {FLAT, BASS, TREBLE, FLAT2} preset_e;
  function automatic logic [4:0] gain_l(preset_e p);
    return p == BASS ? 5'(G_BOOST) : 5'(G_UNITY);
  endfunction
  function automatic logic [4:0] gain_h(preset_e p);
    return p == TREBLE ? 5'(G_BOOST) : 5'(G_UNITY);
  endfunction
endpackage

// File: rtl/au_eq_stage.sv
// au_eq_stage: one-pole crossover with bass/treble gains, bypass and output limiting.
// AU_FILT_SAT_EN selects saturation instead of two's-complement wrap on the output.
module au_eq_stage
  import au_filt_pkg::*;
#(
  parameter int LP_SHIFT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_i,
  input  logic [23:0]     x_i,
  input  logic [2:0]      ctrl_i,
  output logic [EQ_W-1:0] eq_o,
  output logic            vld_o
);
  logic signed [23:0] lp_q, lp_d;
  logic signed [24:0] x_e, diff, lp_s, hp;
  logic signed [30:0] lpw, hpw, xw, glw, ghw, eq_full;
  logic [EQ_W-1:0] eq_q, eq_lim;
  preset_e preset;
  always_comb begin
    preset = preset_e'(ctrl_i[2:1]);
    x_e = {x_i[23], x_i};
    diff = x_e - 25'(lp_q);
    lp_s = 25'(lp_q) + (diff >>> LP_SHIFT);
    lp_d = 24'(lp_s);
    hp = x_e - 25'(lp_d);
    lpw = 31'(lp_d);
    hpw = 31'(hp);
    xw = 31'(x_e);
    glw = 31'(gain_l(preset));
    ghw = 31'(gain_h(preset));
    // hp uses the updated lp so flat gains reproduce x*8 exactly
    eq_full = ctrl_i[0] ? glw * lpw + ghw * hpw : xw <<< 3;
`ifdef AU_FILT_SAT_EN
    eq_lim = eq_full > 31'sd268435455 ? 29'h0FFFFFFF :
             eq_full < -31'sd268435456 ? 29'h10000000 : 29'(eq_full);
`else
    eq_lim = 29'(eq_full);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q <= '0;
      eq_q <= '0;
      vld_o <= 1'b0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) begin
        lp_q <= lp_d;
        eq_q <= eq_lim;
      end
    end
  end
  assign eq_o = eq_q;
endmodule

// File: rtl/au_fir_eq.sv
// au_fir_eq: 16-tap serial-MAC FIR low-pass feeding a bass/treble equalizer.
// AU_FILT_SAT_EN selects saturation instead of two's-complement wrap on the FIR output.
module au_fir_eq
  import au_filt_pkg::*;
#(
  parameter int LP_SHIFT = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        din_vld,
  input  logic [23:0] din,
  input  logic [2:0]  coe_ctrl,
  output logic [23:0] fir_dout,
  output logic        fir_dout_vld,
  output logic [28:0] eq_data,
  output logic        eq_vld
);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(16384);
  logic signed [23:0] x_q [0:NTAPS-1];
  logic signed [ACC_W-1:0] acc_q, xe, ce, prod, sh;
  logic [4:0] cnt_q;
  logic [3:0] tap;
  logic busy_q, fir_vld_q;
  logic [2:0] ctrl_q;
  logic [23:0] fir_q, fir_d;
  always_comb begin
    tap = 4'(cnt_q - 5'd1);
    xe = ACC_W'(x_q[tap]);
    ce = ACC_W'(FIR_COEF[tap]);
    prod = xe * ce;
    sh = (acc_q + RND) >>> 15;
`ifdef AU_FILT_SAT_EN
    fir_d = sh > 44'sd8388607 ? 24'h7FFFFF : sh < -44'sd8388608 ? 24'h800000 : 24'(sh);
`else
    fir_d = 24'(sh);
`endif
  end
  // cnt_q tracks the cycle index after acceptance: 1-16 MAC, 17 round, busy through 19
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      fir_vld_q <= 1'b0;
      ctrl_q <= '0;
      fir_q <= '0;
    end else begin
      fir_vld_q <= busy_q && cnt_q == 5'd17;
      if (!busy_q && din_vld) begin
        for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
        x_q[0] <= din;
        acc_q <= '0;
        cnt_q <= 5'd1;
        busy_q <= 1'b1;
        ctrl_q <= coe_ctrl;
      end else if (busy_q) begin
        cnt_q <= cnt_q + 5'd1;
        busy_q <= cnt_q != 5'd19;
        if (cnt_q <= 5'd16) acc_q <= acc_q + prod;
        if (cnt_q == 5'd17) fir_q <= fir_d;
      end
    end
  end
  au_eq_stage #(.LP_SHIFT(LP_SHIFT)) u_eq (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .vld_i (fir_vld_q),
    .x_i   (fir_q),
    .ctrl_i(ctrl_q),
    .eq_o  (eq_data),
    .vld_o (eq_vld)
  );
  assign fir_dout = fir_q;
  assign fir_dout_vld = fir_vld_q;
endmodule

// File: tb/tb_au_fir_eq.sv
// tb_au_fir_eq: directed and randomized checks of au_fir_eq against an arithmetic reference model.
module tb_au_fir_eq;
  localparam int LPS = 4;
  logic sys_clk = 1'b0;
  logic sys_rst, din_vld;
  logic [23:0] din;
  logic [2:0] coe_ctrl;
  logic [23:0] fir_dout;
  logic fir_dout_vld;
  logic [28:0] eq_data;
  logic eq_vld;
  int vectors = 0, miscompares = 0;
  int coef [16] = '{100, 300, 700, 1200, 1900, 2700, 3900, 5584,
                    5584, 3900, 2700, 1900, 1200, 700, 300, 100};
  longint hist[$];
  longint lp;

  always #10 sys_clk = ~sys_clk;

  au_fir_eq #(.LP_SHIFT(LPS)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .din_vld     (din_vld),
    .din         (din),
    .coe_ctrl    (coe_ctrl),
    .fir_dout    (fir_dout),
    .fir_dout_vld(fir_dout_vld),
    .eq_data     (eq_data),
    .eq_vld      (eq_vld)
  );

  function automatic longint lim(longint v, int w);
    longint m = longint'(1) << w;
    longint r;
`ifdef AU_FILT_SAT_EN
    r = v > m / 2 - 1 ? m / 2 - 1 : v < -m / 2 ? -m / 2 : v;
`else
    r = v & (m - 1);
    r = r >= m / 2 ? r - m : r;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (16) hist.push_back(0);
    lp = 0;
  endtask

  // One accepted sample at cycle 0; checks strobes and values over cycles 1..gap.
  task automatic send(input logic [23:0] d, input logic [2:0] c, input int gap, input bit drop);
    longint acc, x, lpn, hp, gl, gh, e;
    hist.push_front(longint'($signed(d)));
    void'(hist.pop_back());
    acc = 0;
    for (int k = 0; k < 16; k++) acc += hist[k] * coef[k];
    x = lim((acc + 16384) >>> 15, 24);
    lpn = lp + ((x - lp) >>> LPS);
    hp = x - lpn;
    lp = lpn;
    gl = c[2:1] == 2'b01 ? 16 : 8;
    gh = c[2:1] == 2'b10 ? 16 : 8;
    e = lim(c[0] ? gl * lpn + gh * hp : x * 8, 29);
    din = d;
    coe_ctrl = c;
    din_vld = 1'b1;
    for (int n = 1; n <= gap; n++) begin
      @(negedge sys_clk);
      din_vld = 1'b0;
      if (drop && n == 10) begin
        din_vld = 1'b1;
        din = d ^ 24'h5A5A5A;
        coe_ctrl = ~c;
      end
      if (n >= 17 && n <= 20) begin
        chk("fir_vld", fir_dout_vld, n == 18);
        chk("eq_vld", eq_vld, n == 19);
      end
      if (n == 18) chk("fir_dout", $signed(fir_dout), x);
      if (n == 19) chk("eq_data", $signed(eq_data), e);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    din_vld = 1'b1;
    din = 24'h123456;
    coe_ctrl = 3'b111;
    repeat (5) @(negedge sys_clk);
    chk("rst_fir", fir_dout, 0);
    chk("rst_eq", eq_data, 0);
    chk("rst_fir_vld", fir_dout_vld, 0);
    chk("rst_eq_vld", eq_vld, 0);
    din_vld = 1'b0;
    sys_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      chk("idle_fir_vld", fir_dout_vld, 0);
      chk("idle_eq_vld", eq_vld, 0);
    end
    for (int k = 0; k < 16; k++) begin
      send(k == 0 ? 24'h100000 : 24'h0, 3'b000, 1250, 1'b0);
      chk("impulse", $signed(fir_dout), coef[k] * 32);
    end
    for (int i = 0; i < 20; i++) send(24'd1000, 3'b001, 20, 1'b0);
    chk("dc_flat_fir", $signed(fir_dout), 1000);
    chk("dc_flat_eq", $signed(eq_data), 8000);
    for (int i = 0; i < 200; i++) send(24'd1000, 3'b011, 20, 1'b0);
    for (int i = 0; i < 200; i++) send(24'd1000, 3'b101, 20, 1'b0);
    send(24'h0ABCDE, 3'b001, 20, 1'b1);
    for (int i = 0; i < 16; i++) send(24'($urandom), 3'($urandom_range(0, 7)), 20, 1'b0);
    send(24'h654321, 3'b011, 0, 1'b0);
    repeat (10) @(negedge sys_clk);
    din_vld = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_fir", fir_dout, 0);
    chk("midrst_eq", eq_data, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge sys_clk);
      chk("abandon_fir_vld", fir_dout_vld, 0);
      chk("abandon_eq_vld", eq_vld, 0);
    end
    for (int i = 0; i < 150; i++)
      send(24'($urandom), 3'($urandom_range(0, 7)), $urandom_range(20, 30), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 40; i++) send(24'h7FFFFF, 3'b011, 20, 1'b0);
    for (int i = 0; i < 40; i++) send(24'h800000, 3'b101, 20, 1'b0);
    for (int i = 0; i < 40; i++) send(i[0] ? 24'h7FFFFF : 24'h800000, 3'b101, 20, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
